// File: rtl/l2_cacheline_adaptor_if.sv
// Bundles the L2 pmem side and the physical-memory burst side of the cacheline adaptor.
// slave is the adaptor's view; master is the view of whatever drives L2 requests and memory beats.
interface l2_cacheline_adaptor_if #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
);
  logic [ADDR_WIDTH-1:0]  address_i;
  logic                   read_i;
  logic                   write_i;
  logic [LINE_WIDTH-1:0]  line_i;
  logic [LINE_WIDTH-1:0]  line_o;
  logic                   resp_o;
  logic [ADDR_WIDTH-1:0]  address_o;
  logic                   read_o;
  logic                   write_o;
  logic [BURST_WIDTH-1:0] burst_o;
  logic [BURST_WIDTH-1:0] burst_i;
  logic                   resp_i;

  modport slave (
    input  address_i, read_i, write_i, line_i, burst_i, resp_i,
    output line_o, resp_o, address_o, read_o, write_o, burst_o
  );

  modport master (
    output address_i, read_i, write_i, line_i, burst_i, resp_i,
    input  line_o, resp_o, address_o, read_o, write_o, burst_o
  );
endinterface

// File: rtl/l2_cacheline_adaptor.sv
// Splits one L2 line read/write into BEATS memory beats; first beat request 1 cycle after the L2 request,
// resp_o 1 cycle after the last beat. Memory throttles by withholding resp_i; L2 holds its request until resp_o.
module l2_cacheline_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  l2_cacheline_adaptor_if.slave bus
);
  localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF   = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_BURST,
    S_WR_BURST,
    S_DONE
  } state_t;

  state_t                            r_state;
  state_t                            w_state_nxt;
  logic [CNT_W-1:0]                  r_beat_cnt;
  logic [ADDR_WIDTH-1:0]             r_addr;
  logic [BEATS-1:0][BURST_WIDTH-1:0] r_wbuf;
  logic [BEATS-1:0][BURST_WIDTH-1:0] r_line;

  logic                  w_last;
  logic                  w_rd;
  logic                  w_wr;
  logic                  w_resp;
  logic [ADDR_WIDTH-1:0] w_addr_aligned;

  assign w_addr_aligned = {bus.address_i[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
  assign w_last         = (r_beat_cnt == LAST_BEAT);

  always_comb begin
    w_state_nxt = r_state;
    w_rd        = 1'b0;
    w_wr        = 1'b0;
    w_resp      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A simultaneous read and write gives priority to the write-back.
        if (bus.write_i) begin
          w_state_nxt = S_WR_BURST;
        end else if (bus.read_i) begin
          w_state_nxt = S_RD_BURST;
        end
      end
      S_RD_BURST: begin
        w_rd = 1'b1;
        if (bus.resp_i && w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_WR_BURST: begin
        w_wr = 1'b1;
        if (bus.resp_i && w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_resp      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
      r_addr     <= '0;
      r_wbuf     <= '0;
      r_line     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.write_i || bus.read_i) begin
            r_addr     <= w_addr_aligned;
            r_beat_cnt <= '0;
          end
          if (bus.write_i) begin
            r_wbuf <= bus.line_i;
          end
        end
        S_RD_BURST: begin
          if (bus.resp_i) begin
            r_line[r_beat_cnt] <= bus.burst_i;
            r_beat_cnt         <= r_beat_cnt + CNT_W'(1);
          end
        end
        S_WR_BURST: begin
          if (bus.resp_i) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.read_o    = w_rd;
  assign bus.write_o   = w_wr;
  assign bus.resp_o    = w_resp;
  assign bus.address_o = (w_rd || w_wr) ? r_addr : '0;
  assign bus.burst_o   = w_wr ? r_wbuf[r_beat_cnt] : '0;
  assign bus.line_o    = r_line;

  a_no_rd_and_wr: assert property (@(posedge clk) disable iff (!rst_n) !(bus.read_o && bus.write_o));
  a_resp_single:  assert property (@(posedge clk) disable iff (!rst_n) bus.resp_o |=> !bus.resp_o);
endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// Directed bench for l2_cacheline_adaptor: a transaction-level model checked every cycle,
// plus literal expectations for the addresses, beat order and resp timing of each scenario.
module tb_l2_cacheline_adaptor;
  localparam int LW = 256;
  localparam int BW = 64;
  localparam int AW = 32;
  localparam int NB = LW / BW;
  localparam logic [AW-1:0] AMASK = ~AW'(LW / 8 - 1);

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  l2_cacheline_adaptor_if #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

  l2_cacheline_adaptor #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: which line transfer is open, how many beats have moved,
  // and whether the completion pulse is owed this cycle.
  int            m_mode  = 0;  // 0 none, 1 line read, 2 line write
  bit            m_done  = 0;
  int            m_beats = 0;
  logic [AW-1:0] m_addr  = '0;
  logic [BW-1:0] m_line[NB] = '{default: '0};
  logic [BW-1:0] m_wbuf[NB] = '{default: '0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode  = 0;
      m_done  = 0;
      m_beats = 0;
      m_addr  = '0;
      for (int i = 0; i < NB; i++) begin
        m_line[i] = '0;
        m_wbuf[i] = '0;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (m_mode == 0) begin
      if (bus.write_i || bus.read_i) begin
        m_mode  = bus.write_i ? 2 : 1;
        m_addr  = bus.address_i & AMASK;
        m_beats = 0;
        if (bus.write_i)
          for (int i = 0; i < NB; i++) m_wbuf[i] = bus.line_i[i*BW +: BW];
      end
    end else if (bus.resp_i) begin
      if (m_mode == 1) m_line[m_beats] = bus.burst_i;
      m_beats++;
      if (m_beats == NB) begin
        m_mode  = 0;
        m_done  = 1;
        m_beats = 0;
      end
    end
  end

  function automatic logic [LW-1:0] model_line();
    logic [LW-1:0] l;
    for (int i = 0; i < NB; i++) l[i*BW +: BW] = m_line[i];
    return l;
  endfunction

  always @(negedge clk) begin
    chk("m_read_o",    LW'(bus.read_o),    LW'(m_mode == 1));
    chk("m_write_o",   LW'(bus.write_o),   LW'(m_mode == 2));
    chk("m_resp_o",    LW'(bus.resp_o),    LW'(m_done));
    chk("m_address_o", LW'(bus.address_o), LW'((m_mode != 0) ? m_addr : '0));
    chk("m_burst_o",   LW'(bus.burst_o),   LW'((m_mode == 2) ? m_wbuf[m_beats] : '0));
    chk("m_line_o",    bus.line_o,         model_line());
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [BW-1:0] b);
    bus.resp_i  = 1'b1;
    bus.burst_i = b;
    step();
  endtask

  localparam logic [BW-1:0] B1 = 64'h1111_1111_1111_1111;
  localparam logic [BW-1:0] B2 = 64'h2222_2222_2222_2222;
  localparam logic [BW-1:0] B3 = 64'h3333_3333_3333_3333;
  localparam logic [BW-1:0] B4 = 64'h4444_4444_4444_4444;
  localparam logic [BW-1:0] WA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [BW-1:0] WB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [BW-1:0] WC = 64'hCCCC_CCCC_CCCC_CCCC;
  localparam logic [BW-1:0] WD = 64'hDDDD_DDDD_DDDD_DDDD;

  logic [LW-1:0] line1;
  logic [BW-1:0] t2_exp[6];
  logic          t2_rsp[6];
  logic [BW-1:0] gbeat[NB];
  logic [BW-1:0] hbeat[NB];

  initial begin
    rst_n         = 1'b0;
    bus.address_i = '0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.line_i    = '0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
    line1         = {B4, B3, B2, B1};
    t2_exp        = '{WA, WB, WB, WB, WC, WD};
    t2_rsp        = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    gbeat         = '{64'h0A0A_0000_0000_0001, 64'h0A0A_0000_0000_0002,
                      64'h0A0A_0000_0000_0003, 64'h0A0A_0000_0000_0004};
    hbeat         = '{64'h5050_0000_0000_00F0, 64'h5050_0000_0000_00F1,
                      64'h5050_0000_0000_00F2, 64'h5050_0000_0000_00F3};

    @(negedge clk);
    chk("rst_line_o", bus.line_o, '0);
    chk("rst_addr_o", LW'(bus.address_o), '0);
    step();
    rst_n = 1'b1;
    step();

    // 1: line read with four back-to-back beats
    bus.address_i = 32'h0000_1234;
    bus.read_i    = 1'b1;
    step();
    bus.resp_i  = 1'b1;
    bus.burst_i = B1;
    @(negedge clk);
    chk("t1_address_o", LW'(bus.address_o), LW'(32'h0000_1220));
    chk("t1_read_o", LW'(bus.read_o), LW'(1'b1));
    step();
    bus.address_i = 32'hFFFF_FFFF;
    beat(B2);
    beat(B3);
    beat(B4);
    bus.resp_i = 1'b0;
    @(negedge clk);
    chk("t1_resp_cycle5", LW'(bus.resp_o), LW'(1'b1));
    chk("t1_line_o", bus.line_o, line1);
    step();
    bus.read_i = 1'b0;
    @(negedge clk);
    chk("t1_resp_one_cycle", LW'(bus.resp_o), LW'(1'b0));
    step();

    // 2: line write with a two-cycle stall after the first beat
    bus.address_i = 32'h8000_003F;
    bus.line_i    = {WD, WC, WB, WA};
    bus.write_i   = 1'b1;
    step();
    bus.address_i = '0;
    bus.line_i    = '0;
    for (int i = 0; i < 6; i++) begin
      bus.resp_i = t2_rsp[i];
      @(negedge clk);
      chk("t2_burst_o", LW'(bus.burst_o), LW'(t2_exp[i]));
      chk("t2_address_o", LW'(bus.address_o), LW'(32'h8000_0020));
      step();
    end
    bus.resp_i = 1'b0;
    @(negedge clk);
    chk("t2_resp_o", LW'(bus.resp_o), LW'(1'b1));
    chk("t2_write_o_done", LW'(bus.write_o), LW'(1'b0));
    step();
    bus.write_i = 1'b0;
    step();

    // 3: read and write together, the write wins
    bus.address_i = 32'h0000_0040;
    bus.line_i    = {4{64'h0123_4567_89AB_CDEF}};
    bus.read_i    = 1'b1;
    bus.write_i   = 1'b1;
    step();
    for (int i = 0; i < NB; i++) begin
      bus.resp_i = 1'b1;
      @(negedge clk);
      chk("t3_write_o", LW'(bus.write_o), LW'(1'b1));
      chk("t3_read_o", LW'(bus.read_o), LW'(1'b0));
      step();
    end
    bus.resp_i = 1'b0;
    @(negedge clk);
    chk("t3_resp_o", LW'(bus.resp_o), LW'(1'b1));
    chk("t3_line_o_kept", bus.line_o, line1);
    step();
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
    step();

    // 4: reset asserted mid-read, then a clean read
    bus.address_i = 32'h0000_0100;
    bus.read_i    = 1'b1;
    step();
    beat(64'hDEAD_0000_0000_0000);
    beat(64'hDEAD_0000_0000_0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_read_o", LW'(bus.read_o), '0);
    chk("t4_rst_address_o", LW'(bus.address_o), '0);
    chk("t4_rst_line_o", bus.line_o, '0);
    chk("t4_rst_resp_o", LW'(bus.resp_o), '0);
    bus.read_i = 1'b0;
    bus.resp_i = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();
    bus.address_i = 32'h0000_2000;
    bus.read_i    = 1'b1;
    step();
    for (int i = 0; i < NB; i++) beat(hbeat[i]);
    bus.resp_i = 1'b0;
    @(negedge clk);
    chk("t4_resp_o", LW'(bus.resp_o), LW'(1'b1));
    chk("t4_line_o", bus.line_o, {hbeat[3], hbeat[2], hbeat[1], hbeat[0]});
    step();
    bus.read_i = 1'b0;
    step();

    // 5/6: stray resp_i in IDLE and DONE, then a write straight after resp_o
    bus.resp_i  = 1'b1;
    bus.burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
    step();
    bus.resp_i = 1'b0;
    @(negedge clk);
    chk("t5_idle_resp_o", LW'(bus.resp_o), LW'(1'b0));
    chk("t5_idle_read_o", LW'(bus.read_o), LW'(1'b0));
    bus.address_i = 32'h0000_3000;
    bus.read_i    = 1'b1;
    step();
    for (int i = 0; i < NB; i++) beat(gbeat[i]);
    bus.resp_i  = 1'b1;
    bus.burst_i = 64'hBAD1_BAD1_BAD1_BAD1;
    @(negedge clk);
    chk("t5_done_resp_o", LW'(bus.resp_o), LW'(1'b1));
    step();
    bus.resp_i    = 1'b0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b1;
    bus.address_i = 32'h0000_4000;
    bus.line_i    = {hbeat[3] ^ 64'hFF, hbeat[2] ^ 64'hFF, hbeat[1] ^ 64'hFF, hbeat[0] ^ 64'hFF};
    @(negedge clk);
    chk("t6_no_stale_resp", LW'(bus.resp_o), LW'(1'b0));
    step();
    for (int i = 0; i < NB; i++) begin
      bus.resp_i = 1'b1;
      @(negedge clk);
      chk("t6_burst_o", LW'(bus.burst_o), LW'(hbeat[i] ^ 64'hFF));
      chk("t6_line_o_kept", bus.line_o, {gbeat[3], gbeat[2], gbeat[1], gbeat[0]});
      step();
    end
    bus.resp_i = 1'b0;
    @(negedge clk);
    chk("t6_resp_o", LW'(bus.resp_o), LW'(1'b1));
    step();
    bus.write_i = 1'b0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
